// File: rtl/fpu_result_checker.sv
// Result-side scoreboard checker: pops one golden entry per accepted FPU result and tallies matches.
// Latency: accept -> pass/fail counts 1 cycle, counts -> done_o 1 cycle.
// Backpressure: res_ready_o drops on empty scoreboard, LFSR stall or outside RUN; exp_ready_o drops when full or done.
module fpu_result_checker #(
  parameter int unsigned EXP_BITS  = 5,
  parameter int unsigned MAN_BITS  = 10,
  parameter int unsigned DEPTH     = 8,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  localparam int unsigned WIDTH    = 1 + EXP_BITS + MAN_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             exp_valid_i,
  output logic             exp_ready_o,
  input  logic [WIDTH-1:0] exp_data_i,
  input  logic [4:0]       exp_flags_i,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic [WIDTH-1:0] res_data_i,
  input  logic [4:0]       res_flags_i,
  input  logic             stall_en_i,
  input  logic             check_flags_i,
  input  logic [15:0]      num_expected_i,
  output logic [15:0]      pass_cnt_o,
  output logic [15:0]      fail_cnt_o,
  output logic [15:0]      first_err_o,
  output logic             err_o,
  output logic             orphan_o,
  output logic             done_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [4:0]       flags;
    logic [WIDTH-1:0] data;
  } sb_entry_t;

  logic [1:0]  state_q;
  logic [7:0]  lfsr_q;
  logic        lfsr_fb;
  logic        stall;

  sb_entry_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        accept;
  sb_entry_t   head;

  logic        cmp_vld_q;
  sb_entry_t   cmp_res_q;
  sb_entry_t   cmp_exp_q;
  logic [15:0] cmp_idx_q;
  logic [15:0] acc_idx_q;

  logic        data_ok;
  logic        flags_ok;
  logic        match;
  logic [16:0] run_sum;
  logic        run_done;

  function automatic logic is_nan(input logic [WIDTH-1:0] v);
    return (&v[WIDTH-2:MAN_BITS]) && (|v[MAN_BITS-1:0]);
  endfunction

  // Extra pointer bit distinguishes full from empty when the index bits coincide.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  assign lfsr_fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign stall       = stall_en_i && (lfsr_q[1:0] == 2'b00);

  // Readiness is masked during reset so every output reads 0 while rst_ni is low.
  assign exp_ready_o = rst_ni && !fifo_full && (state_q != ST_DONE);
  assign res_ready_o = !fifo_empty && !stall && (state_q == ST_RUN);
  assign push        = exp_valid_i && exp_ready_o;
  assign accept      = res_valid_i && res_ready_o;
  assign done_o      = (state_q == ST_DONE);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {exp_flags_i, exp_data_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (accept) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_vld_q <= 1'b0;
      cmp_res_q <= '0;
      cmp_exp_q <= '0;
      cmp_idx_q <= '0;
      acc_idx_q <= '0;
    end else begin
      cmp_vld_q <= accept;
      if (accept) begin
        cmp_res_q <= {res_flags_i, res_data_i};
        cmp_exp_q <= head;
        cmp_idx_q <= acc_idx_q;
        acc_idx_q <= acc_idx_q + 16'd1;
      end
    end
  end

  // A NaN golden value accepts any NaN payload; everything else is bit-exact.
  assign data_ok  = is_nan(cmp_exp_q.data) ? is_nan(cmp_res_q.data)
                                           : (cmp_res_q.data == cmp_exp_q.data);
  assign flags_ok = !check_flags_i || (cmp_res_q.flags == cmp_exp_q.flags);
  assign match    = data_ok && flags_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pass_cnt_o  <= '0;
      fail_cnt_o  <= '0;
      first_err_o <= '0;
      err_o       <= 1'b0;
    end else if (cmp_vld_q) begin
      if (match) begin
        if (pass_cnt_o != 16'hFFFF) begin
          pass_cnt_o <= pass_cnt_o + 16'd1;
        end
      end else begin
        if (fail_cnt_o != 16'hFFFF) begin
          fail_cnt_o <= fail_cnt_o + 16'd1;
        end
        if (!err_o) begin
          first_err_o <= cmp_idx_q;
          err_o       <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      orphan_o <= 1'b0;
    end else if ((state_q == ST_RUN) && fifo_empty && res_valid_i) begin
      orphan_o <= 1'b1;
    end
  end

  // Completion looks at the registered counts, adding one cycle after the last update.
  assign run_sum  = {1'b0, pass_cnt_o} + {1'b0, fail_cnt_o};
  assign run_done = (num_expected_i != 16'd0) && (run_sum == {1'b0, num_expected_i});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (push)     state_q <= ST_RUN;
        ST_RUN:  if (run_done) state_q <= ST_DONE;
        ST_DONE: state_q <= ST_DONE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_result_checker.sv
// Directed bench for fpu_result_checker: scoreboard of pushed goldens and planned results,
// with a cycle model of handshakes, counts, completion and the backpressure LFSR.
module tb_fpu_result_checker;

  localparam int DEPTH = 8;
  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_RUN  = 2'd1;
  localparam logic [1:0] M_DONE = 2'd2;

  typedef struct packed { logic [15:0] d; logic [4:0] f; } ent_t;
  typedef struct packed { logic [15:0] d; logic [4:0] f; logic ok; } res_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        exp_valid_i = 1'b0;
  logic        exp_ready_o;
  logic [15:0] exp_data_i = '0;
  logic [4:0]  exp_flags_i = '0;
  logic        res_valid_i = 1'b0;
  logic        res_ready_o;
  logic [15:0] res_data_i = '0;
  logic [4:0]  res_flags_i = '0;
  logic        stall_en_i = 1'b0;
  logic        check_flags_i = 1'b1;
  logic [15:0] num_expected_i = '0;
  logic [15:0] pass_cnt_o;
  logic [15:0] fail_cnt_o;
  logic [15:0] first_err_o;
  logic        err_o;
  logic        orphan_o;
  logic        done_o;

  fpu_result_checker dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o),
    .exp_data_i(exp_data_i), .exp_flags_i(exp_flags_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_data_i(res_data_i), .res_flags_i(res_flags_i),
    .stall_en_i(stall_en_i), .check_flags_i(check_flags_i),
    .num_expected_i(num_expected_i),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o), .first_err_o(first_err_o),
    .err_o(err_o), .orphan_o(orphan_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  ent_t push_q[$];
  res_t plan_q[$];

  int         total = 0;
  int         bad = 0;
  int         occ, m_pass, m_fail, m_acc, m_first, prev_idx, stall_obs;
  logic [1:0] m_state;
  logic [7:0] m_lfsr;
  bit         m_err, m_orph, prev_v, prev_ok;
  bit         push_en, res_en, force_res;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    exp_valid_i = push_en && (push_q.size() > 0);
    if (push_q.size() > 0) begin
      exp_data_i  = push_q[0].d;
      exp_flags_i = push_q[0].f;
    end
    res_valid_i = res_en && (plan_q.size() > 0) && ((occ > 0) || force_res);
    if (plan_q.size() > 0) begin
      res_data_i  = plan_q[0].d;
      res_flags_i = plan_q[0].f;
    end
  endtask

  task automatic tick();
    bit eh, rh, orph, ok, rdy_e, rdy_r;
    drive();
    #1;
    rdy_e = (m_state != M_DONE) && (occ < DEPTH);
    rdy_r = (m_state == M_RUN) && (occ > 0) && !(stall_en_i && (m_lfsr[1:0] == 2'b00));
    chk("exp_ready", 64'(exp_ready_o), 64'(rdy_e));
    chk("res_ready", 64'(res_ready_o), 64'(rdy_r));
    if (res_valid_i && !res_ready_o) stall_obs++;
    eh   = exp_valid_i && rdy_e;
    rh   = res_valid_i && rdy_r;
    orph = (m_state == M_RUN) && (occ == 0) && res_valid_i;
    ok   = 1'b0;
    if (eh) void'(push_q.pop_front());
    if (rh) begin
      ok = plan_q[0].ok;
      void'(plan_q.pop_front());
    end
    @(posedge clk_i);
    if (m_state == M_RUN && num_expected_i != 16'd0 && (m_pass + m_fail) == int'(num_expected_i))
      m_state = M_DONE;
    else if (m_state == M_IDLE && eh)
      m_state = M_RUN;
    if (prev_v) begin
      if (prev_ok) m_pass++;
      else begin
        m_fail++;
        if (!m_err) begin
          m_err   = 1'b1;
          m_first = prev_idx;
        end
      end
    end
    prev_v   = rh;
    prev_ok  = ok;
    prev_idx = m_acc;
    if (rh) m_acc++;
    if (orph) m_orph = 1'b1;
    occ    = occ + int'(eh) - int'(rh);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    @(negedge clk_i);
    chk("pass_cnt", 64'(pass_cnt_o), 64'(m_pass));
    chk("fail_cnt", 64'(fail_cnt_o), 64'(m_fail));
    chk("err", 64'(err_o), 64'(m_err));
    chk("first_err", 64'(first_err_o), 64'(m_first));
    chk("orphan", 64'(orphan_o), 64'(m_orph));
    chk("done", 64'(done_o), 64'(m_state == M_DONE));
  endtask

  task automatic run(input string tag);
    int n = 0;
    while (((push_en && push_q.size() > 0) || (res_en && plan_q.size() > 0)) && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 64'((push_en ? push_q.size() : 0) + (res_en ? plan_q.size() : 0)), 64'(0));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    push_en = 1'b0; res_en = 1'b0; force_res = 1'b0;
    exp_valid_i = 1'b0; res_valid_i = 1'b0;
    push_q.delete(); plan_q.delete();
    occ = 0; m_pass = 0; m_fail = 0; m_acc = 0; m_first = 0; prev_idx = 0;
    m_state = M_IDLE; m_lfsr = 8'hA5; m_err = 1'b0; m_orph = 1'b0; prev_v = 1'b0; prev_ok = 1'b0;
    #1;
    chk("rst_counts", 64'({pass_cnt_o, fail_cnt_o, first_err_o}), 64'(0));
    chk("rst_flags", 64'({err_o, orphan_o, done_o, exp_ready_o, res_ready_o}), 64'(0));
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before test end");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk_i);

    // Four identical results; done_o lands two cycles after the last accept.
    do_reset();
    num_expected_i = 16'd4;
    for (int i = 0; i < 4; i++) begin
      push_q.push_back('{d: 16'h3C00, f: 5'd0});
      plan_q.push_back('{d: 16'h3C00, f: 5'd0, ok: 1'b1});
    end
    push_en = 1'b1; run("t1_push");
    res_en = 1'b1;  run("t1_res");
    chk("t1_done_lat0", 64'(done_o), 64'(0));
    tick();
    chk("t1_pass", 64'(pass_cnt_o), 64'(4));
    chk("t1_done_lat1", 64'(done_o), 64'(0));
    tick();
    chk("t1_done_lat2", 64'(done_o), 64'(1));
    chk("t1_fail", 64'(fail_cnt_o), 64'(0));

    // Third of five results is off by one ulp.
    do_reset();
    num_expected_i = 16'd5;
    for (int i = 0; i < 5; i++) begin
      push_q.push_back('{d: 16'h4000, f: 5'd0});
      plan_q.push_back('{d: (i == 2) ? 16'h4001 : 16'h4000, f: 5'd0, ok: (i != 2)});
    end
    push_en = 1'b1; run("t2_push");
    res_en = 1'b1;  run("t2_res");
    repeat (2) tick();
    chk("t2_pass", 64'(pass_cnt_o), 64'(4));
    chk("t2_fail", 64'(fail_cnt_o), 64'(1));
    chk("t2_first_err", 64'(first_err_o), 64'(2));
    chk("t2_err", 64'(err_o), 64'(1));
    chk("t2_done", 64'(done_o), 64'(1));

    // NaN payloads match each other; inf does not match NaN; flags ignored when disabled.
    do_reset();
    check_flags_i = 1'b0;
    num_expected_i = 16'd3;
    push_q.push_back('{d: 16'h7E00, f: 5'd0});
    push_q.push_back('{d: 16'h7E00, f: 5'd0});
    push_q.push_back('{d: 16'h3C00, f: 5'b00001});
    plan_q.push_back('{d: 16'h7C01, f: 5'd0, ok: 1'b1});
    plan_q.push_back('{d: 16'h7C00, f: 5'd0, ok: 1'b0});
    plan_q.push_back('{d: 16'h3C00, f: 5'd0, ok: 1'b1});
    push_en = 1'b1; run("t3_push");
    res_en = 1'b1;  run("t3_res");
    repeat (2) tick();
    chk("t3_pass", 64'(pass_cnt_o), 64'(2));
    chk("t3_fail", 64'(fail_cnt_o), 64'(1));
    chk("t3_first_err", 64'(first_err_o), 64'(1));
    check_flags_i = 1'b1;

    // Full scoreboard refuses a push even while popping; the held entry goes in next cycle.
    do_reset();
    num_expected_i = 16'd9;
    for (int i = 0; i < 9; i++) begin
      push_q.push_back('{d: 16'h1000 + 16'(i), f: 5'(i)});
      plan_q.push_back('{d: 16'h1000 + 16'(i), f: (i == 4) ? 5'h1F : 5'(i), ok: (i != 4)});
    end
    push_en = 1'b1;
    repeat (8) tick();
    drive(); #1;
    chk("t4_full_exp_rdy", 64'(exp_ready_o), 64'(0));
    res_en = 1'b1;
    drive(); #1;
    chk("t4_pop_rdy", 64'(res_ready_o), 64'(1));
    tick();
    drive(); #1;
    chk("t4_after_pop_exp_rdy", 64'(exp_ready_o), 64'(1));
    run("t4_res");
    repeat (2) tick();
    chk("t4_pass", 64'(pass_cnt_o), 64'(8));
    chk("t4_fail", 64'(fail_cnt_o), 64'(1));
    chk("t4_first_err", 64'(first_err_o), 64'(4));
    chk("t4_done", 64'(done_o), 64'(1));

    // Random backpressure over 64 results with interleaved pushes.
    do_reset();
    stall_en_i = 1'b1;
    stall_obs = 0;
    num_expected_i = 16'd64;
    for (int i = 0; i < 64; i++) begin
      push_q.push_back('{d: 16'h2000 + 16'(i), f: 5'd0});
      plan_q.push_back('{d: 16'h2000 + 16'(i), f: 5'd0, ok: 1'b1});
    end
    push_en = 1'b1; res_en = 1'b1;
    run("t5");
    repeat (2) tick();
    chk("t5_pass", 64'(pass_cnt_o), 64'(64));
    chk("t5_fail", 64'(fail_cnt_o), 64'(0));
    chk("t5_done", 64'(done_o), 64'(1));
    chk("t5_stalls_seen", 64'(stall_obs > 0), 64'(1));
    stall_en_i = 1'b0;

    // Reset with entries queued discards them and restarts the counts.
    do_reset();
    num_expected_i = 16'd0;
    for (int i = 0; i < 3; i++) push_q.push_back('{d: 16'h3C00, f: 5'd0});
    plan_q.push_back('{d: 16'h3C00, f: 5'd0, ok: 1'b1});
    push_en = 1'b1; run("t6_push");
    res_en = 1'b1;  run("t6_res");
    tick();
    chk("t6_pre_pass", 64'(pass_cnt_o), 64'(1));
    do_reset();
    num_expected_i = 16'd1;
    push_q.push_back('{d: 16'h5555, f: 5'd0});
    plan_q.push_back('{d: 16'h5555, f: 5'd0, ok: 1'b1});
    push_en = 1'b1; run("t6b_push");
    res_en = 1'b1;  run("t6b_res");
    repeat (2) tick();
    chk("t6_pass", 64'(pass_cnt_o), 64'(1));
    chk("t6_fail", 64'(fail_cnt_o), 64'(0));
    chk("t6_done", 64'(done_o), 64'(1));

    // A result offered with an empty scoreboard in RUN is flagged and not consumed.
    do_reset();
    num_expected_i = 16'd0;
    push_q.push_back('{d: 16'h4200, f: 5'd0});
    plan_q.push_back('{d: 16'h4200, f: 5'd0, ok: 1'b1});
    plan_q.push_back('{d: 16'h1234, f: 5'd0, ok: 1'b0});
    push_en = 1'b1; run("t7_push");
    res_en = 1'b1;
    for (int n = 0; n < 50 && plan_q.size() > 1; n++) tick();
    force_res = 1'b1;
    drive(); #1;
    chk("t7_rdy_low", 64'(res_ready_o), 64'(0));
    tick();
    chk("t7_orphan", 64'(orphan_o), 64'(1));
    tick();
    chk("t7_not_consumed", 64'(pass_cnt_o + fail_cnt_o), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
